// File: rtl/moving_sum_pkg.sv
// Shared types and helpers for the moving-window sum.
//   state_t    : FILL while the window is still filling, RUN once it is full.
//   calc_sum_w : accumulator width that can hold MAX_LEN full-scale samples.
//   clamp_len  : maps a requested window length into 1..max_len.
package moving_sum_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned calc_sum_w(input int unsigned data_w,
                                             input int unsigned depth_log2);
    return data_w + depth_log2;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned max_len);
    if (req == 0) begin
      return 1;
    end else if (req > max_len) begin
      return max_len;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/moving_sum_win_sample_ring.sv
// Circular sample history for the moving-window sum.
// Writes din at the write pointer on wr and advances it (mod MAX_LEN).
// old is read combinationally at wp - len, i.e. the sample leaving the window.
// len == 0 here encodes a window of MAX_LEN, which reads the slot about to be
// overwritten.
//   clk, rst : clock, asynchronous active-high reset (clears wp only)
//   wr, din  : accepted-sample write port
//   len      : window length modulo MAX_LEN
//   old      : expired sample
module sample_ring #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DEPTH_LOG2-1:0] len,
  output logic [DATA_W-1:0]     old
);

  localparam int unsigned MAX_LEN = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [MAX_LEN];
  logic [DEPTH_LOG2-1:0] wp;

  // Write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
    end else if (wr) begin
      wp <= wp + DEPTH_LOG2'(1);
    end
  end

  // History storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp] <= din;
    end
  end

  assign old = mem[wp - len];

endmodule

// File: rtl/moving_sum_win.sv
// Moving-window sum over the last len_r accepted samples with internal history.
// Build option: define MOVING_SUM_SIGNED_EN for two's-complement din/sum;
// otherwise din and sum are unsigned.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear; latches clamped win_len and restarts window
//   win_len   : requested window length, sampled only on clr
//   wr, din   : sample strobe and sample
//   sum       : sum of the last len_r samples (fewer while filling)
//   sum_stb   : one-cycle pulse after each accepted sample
//   sum_valid : window has filled since the last clear
module moving_sum_win
  import moving_sum_pkg::*;
#(
  parameter  int unsigned DATA_W     = 16,
  parameter  int unsigned DEPTH_LOG2 = 4,
  localparam int unsigned SUM_W      = calc_sum_w(DATA_W, DEPTH_LOG2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DEPTH_LOG2:0]   win_len,
  input  logic                  wr,
  input  logic [DATA_W-1:0]     din,
  output logic [SUM_W-1:0]      sum,
  output logic                  sum_stb,
  output logic                  sum_valid
);

  localparam int unsigned MAX_LEN = 2 ** DEPTH_LOG2;
  localparam int unsigned LEN_W   = DEPTH_LOG2 + 1;
  localparam int unsigned EXT_W   = SUM_W - DATA_W;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     count_q, count_d;
  logic [SUM_W-1:0]     sum_d;
  logic                 sum_stb_d;
  logic                 sum_valid_d;
  logic                 accept_c;
  logic [DATA_W-1:0]    old;
  logic [SUM_W-1:0]     din_ext;
  logic [SUM_W-1:0]     old_ext;

  // clr wins over a simultaneous wr, so the ring only sees accepted samples
  assign accept_c = wr && !clr;

  sample_ring #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ring (
    .clk (clk),
    .rst (rst),
    .wr  (accept_c),
    .din (din),
    .len (len_q[DEPTH_LOG2-1:0]),
    .old (old)
  );

  // Operand extension to accumulator width
`ifdef MOVING_SUM_SIGNED_EN
  assign din_ext = {{EXT_W{din[DATA_W-1]}}, din};
  assign old_ext = {{EXT_W{old[DATA_W-1]}}, old};
`else
  assign din_ext = {{EXT_W{1'b0}}, din};
  assign old_ext = {{EXT_W{1'b0}}, old};
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      len_q     <= LEN_W'(MAX_LEN);
      count_q   <= '0;
      sum       <= '0;
      sum_stb   <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      sum       <= sum_d;
      sum_stb   <= sum_stb_d;
      sum_valid <= sum_valid_d;
    end
  end

  // Next-state and accumulator update
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum;
    sum_stb_d   = 1'b0;
    sum_valid_d = sum_valid;

    if (clr) begin
      len_d       = LEN_W'(clamp_len(32'(win_len), MAX_LEN));
      count_d     = '0;
      sum_d       = '0;
      sum_valid_d = 1'b0;
      state_d     = FILL;
    end else if (wr) begin
      sum_stb_d = 1'b1;
      unique case (state_q)
        FILL: begin
          sum_d   = sum + din_ext;
          count_d = count_q + LEN_W'(1);
          if (count_d == len_q) begin
            state_d     = RUN;
            sum_valid_d = 1'b1;
          end
        end
        RUN: begin
          sum_d = sum + din_ext - old_ext;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moving_sum_win.sv
// Self-checking bench for moving_sum_win (DATA_W=16, DEPTH_LOG2=4, SUM_W=20).
// A table of per-cycle {inputs, expected outputs} rows is built up front and
// applied one row per clock; a few hand-written sequences cover async reset.
module tb_moving_sum_win;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned SUM_W      = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [4:0]        win_len;
  logic              wr;
  logic [15:0]       din;
  logic [SUM_W-1:0]  sum;
  logic              sum_stb;
  logic              sum_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        clr;
    logic [4:0]  win_len;
    logic        wr;
    logic [15:0] din;
    logic [19:0] sum;
    logic        stb;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  moving_sum_win #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .win_len   (win_len),
    .wr        (wr),
    .din       (din),
    .sum       (sum),
    .sum_stb   (sum_stb),
    .sum_valid (sum_valid)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic c, input logic [4:0] wl,
                     input logic w, input logic [15:0] d,
                     input logic [19:0] s, input logic st, input logic v);
    vec_t e;
    e.rst = r; e.clr = c; e.win_len = wl; e.wr = w; e.din = d;
    e.sum = s; e.stb = st; e.valid = v;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [4:0] wl,
                       input logic w, input logic [15:0] d);
    rst = r; clr = c; win_len = wl; wr = w; din = d;
  endtask

  initial begin
    logic [19:0] e;
    int k;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) add(1, 0, 5'd0, 1, 16'd7, 20'd0, 0, 0);
    // Default window 16 after reset, filling
    add(0, 0, 5'd0, 1, 16'd7, 20'd7,  1, 0);
    add(0, 0, 5'd0, 1, 16'd7, 20'd14, 1, 0);
    add(0, 0, 5'd0, 1, 16'd7, 20'd21, 1, 0);
    add(0, 0, 5'd0, 0, 16'd0, 20'd21, 0, 0);
    // Window of 4
    add(0, 1, 5'd4, 0, 16'd0, 20'd0,  0, 0);
    add(0, 0, 5'd4, 1, 16'd1, 20'd1,  1, 0);
    add(0, 0, 5'd4, 1, 16'd2, 20'd3,  1, 0);
    add(0, 0, 5'd4, 1, 16'd3, 20'd6,  1, 0);
    add(0, 0, 5'd4, 1, 16'd4, 20'd10, 1, 1);
    add(0, 0, 5'd4, 1, 16'd5, 20'd14, 1, 1);
    add(0, 0, 5'd4, 1, 16'd6, 20'd18, 1, 1);
    add(0, 0, 5'd4, 0, 16'd0, 20'd18, 0, 1);
    // win_len change without clr is ignored; gap then 7 replaces 3
    add(0, 0, 5'd1, 1, 16'd7, 20'd22, 1, 1);
    // Full scale, window 16
    add(0, 1, 5'd16, 0, 16'd0, 20'd0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      k = (i > 16) ? 16 : i;
`ifdef MOVING_SUM_SIGNED_EN
      e = 20'(-k);
`else
      e = 20'(k * 65535);
`endif
      add(0, 0, 5'd16, 1, 16'hFFFF, e, 1, (i >= 16));
    end
    // Clamp 0 -> 1
    add(0, 1, 5'd0, 0, 16'd0, 20'd0, 0, 0);
    add(0, 0, 5'd0, 1, 16'd5, 20'd5, 1, 1);
    add(0, 0, 5'd0, 1, 16'd9, 20'd9, 1, 1);
    // Clamp 31 -> 16
    add(0, 1, 5'd31, 0, 16'd0, 20'd0, 0, 0);
    for (int i = 1; i <= 18; i++) begin
      k = (i > 16) ? 16 : i;
      add(0, 0, 5'd31, 1, 16'd1, 20'(k), 1, (i >= 16));
    end
    // clr + wr collision drops the sample
    add(0, 1, 5'd4, 1, 16'd100, 20'd0, 0, 0);
    add(0, 0, 5'd4, 1, 16'd3,   20'd3, 1, 0);
    add(0, 0, 5'd4, 0, 16'd0,   20'd3, 0, 0);
`ifdef MOVING_SUM_SIGNED_EN
    // Signed window of 4 with -1 samples
    add(0, 1, 5'd4, 0, 16'd0, 20'd0, 0, 0);
    add(0, 0, 5'd4, 1, 16'hFFFF, 20'hFFFFF, 1, 0);
    add(0, 0, 5'd4, 1, 16'hFFFF, 20'hFFFFE, 1, 0);
    add(0, 0, 5'd4, 1, 16'hFFFF, 20'hFFFFD, 1, 0);
    add(0, 0, 5'd4, 1, 16'hFFFF, 20'hFFFFC, 1, 1);
    add(0, 0, 5'd4, 1, 16'hFFFF, 20'hFFFFC, 1, 1);
`endif

    drive(1, 0, 5'd0, 0, 16'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].win_len, vecs[i].wr, vecs[i].din);
      @(posedge clk);
      #1;
      chk("sum",       i, 32'(sum),       32'(vecs[i].sum));
      chk("sum_stb",   i, 32'(sum_stb),   32'(vecs[i].stb));
      chk("sum_valid", i, 32'(sum_valid), 32'(vecs[i].valid));
    end

    // Mid-stream async reset: window 4, fill to valid, then rst between edges
    drive(0, 1, 5'd4, 0, 16'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 5'd4, 1, 16'd9);
      @(posedge clk); #1;
    end
    chk("pre_rst_sum",   900, 32'(sum),       32'd36);
    chk("pre_rst_valid", 900, 32'(sum_valid), 32'd1);
    drive(0, 0, 5'd4, 0, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sum",   901, 32'(sum),       32'd0);
    chk("async_rst_stb",   901, 32'(sum_stb),   32'd0);
    chk("async_rst_valid", 901, 32'(sum_valid), 32'd0);
    @(posedge clk); #1;
    // wr held during reset must be ignored
    drive(1, 0, 5'd4, 1, 16'd50);
    @(posedge clk); #1;
    chk("rst_hold_sum", 902, 32'(sum), 32'd0);
    chk("rst_hold_stb", 902, 32'(sum_stb), 32'd0);
    // After reset the window is back to 16: four samples do not fill it
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 5'd4, 1, 16'd2);
      @(posedge clk); #1;
      chk("post_rst_sum",   902 + i, 32'(sum),       32'(2 * i));
      chk("post_rst_valid", 902 + i, 32'(sum_valid), 32'd0);
    end
    drive(0, 0, 5'd4, 0, 16'd0);
    @(posedge clk); #1;
    chk("post_rst_stb_idle", 907, 32'(sum_stb), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
